// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with per-entry saturating direction counters.
// Fetch side: PCF/PCPlus4F in, P_PC/TakenF out, zero-latency lookup.
// Execute side: upd_* resolved outcome in, mispredict/redirect_pc out, table written at the edge.
// bp_clear invalidates every entry at the next edge; rst is asynchronous, active-high.
// Optional BP_STATS_EN adds saturating stat_branches/stat_mispredicts/stat_hits counters.
module branch_target_predictor #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  output logic [XLEN-1:0] P_PC,
  output logic            TakenF,
  input  logic            bp_clear,
  input  logic            upd_valid,
  input  logic            upd_is_jump,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
  output logic [31:0]     stat_hits
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jmp;
  logic [TAG_W-1:0] tag_mem [ENTRIES];
  logic [XLEN-1:0] tgt_mem [ENTRIES];
  logic [CNT_W-1:0] cnt_mem [ENTRIES];
  logic [IDX_W-1:0] idx_f, idx_u;
  logic [TAG_W-1:0] tag_f, tag_u;
  logic hit_f, hit_u;
  logic [CNT_W-1:0] cnt_u, cnt_nxt;
  logic unused_pc;
  always_comb begin
    idx_f = PCF[IDX_W+1:2];
    tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
    idx_u = upd_pc[IDX_W+1:2];
    tag_u = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    unused_pc = ^PCF;
    hit_f = valid[idx_f] && tag_mem[idx_f] == tag_f;
    hit_u = valid[idx_u] && tag_mem[idx_u] == tag_u;
    TakenF = hit_f && (jmp[idx_f] || cnt_mem[idx_f][CNT_W-1]);
    P_PC = TakenF ? tgt_mem[idx_f] : PCPlus4F;
    cnt_u = cnt_mem[idx_u];
    cnt_nxt = upd_taken ? (cnt_u == CNT_MAX ? cnt_u : cnt_u + CNT_W'(1))
                        : (cnt_u == '0 ? cnt_u : cnt_u - CNT_W'(1));
    mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                               (upd_taken && upd_pred_target != upd_target));
    redirect_pc = !upd_valid ? '0 : upd_taken ? upd_target : upd_pc + XLEN'(4);
  end
  // A hit rewrites valid/tag with the values already stored, so hit and allocate share one write path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      jmp <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
        cnt_mem[i] <= CNT_WNT;
      end
    end else if (bp_clear) begin
      valid <= '0;
    end else if (upd_valid && (hit_u || upd_taken)) begin
      valid[idx_u] <= 1'b1;
      tag_mem[idx_u] <= tag_u;
      jmp[idx_u] <= upd_is_jump;
      cnt_mem[idx_u] <= hit_u ? cnt_nxt : CNT_WT;
      if (upd_taken) tgt_mem[idx_u] <= upd_target;
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bp_clear) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
      stat_hits <= '0;
    end else begin
      stat_branches <= stat_branches + 32'(upd_valid && stat_branches != '1);
      stat_mispredicts <= stat_mispredicts + 32'(mispredict && stat_mispredicts != '1);
      stat_hits <= stat_hits + 32'(hit_f && stat_hits != '1);
    end
  end
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: scoreboard bench for branch_target_predictor.
module tb_branch_target_predictor;
  logic clk = 0, rst = 1;
  logic [31:0] PCF = 0, PCPlus4F = 4, P_PC, upd_pc = 0, upd_target = 0, upd_pred_target = 0, redirect_pc;
  logic TakenF, bp_clear = 0, upd_valid = 0, upd_is_jump = 0, upd_taken = 0, upd_pred_taken = 0, mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts, stat_hits;
`endif
  typedef struct {
    string n;
    logic [65:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;

  branch_target_predictor dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PCPlus4F(PCPlus4F), .P_PC(P_PC), .TakenF(TakenF),
    .bp_clear(bp_clear), .upd_valid(upd_valid), .upd_is_jump(upd_is_jump), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts), .stat_hits(stat_hits)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] got();
    return {TakenF, P_PC, mispredict, redirect_pc};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    PCF = pc;
    PCPlus4F = pc + 32'd4;
  endtask

  task automatic upd(input logic uv, input logic uj, input logic [31:0] pc, input logic t,
                     input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    upd_valid = uv;
    upd_is_jump = uj;
    upd_pc = pc;
    upd_taken = t;
    upd_target = tg;
    upd_pred_taken = pt;
    upd_pred_target = ptg;
  endtask

  task automatic idle();
    upd(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic want(input string n, input logic t, input logic [31:0] p, input logic m, input logic [31:0] r);
    q.push_back('{n, {t, p, m, r}});
  endtask

  task automatic test_reset();
    fetch(32'h40); idle(); want("rst_held", 0, 32'h44, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); rst = 0; want("rst_release", 0, 32'h44, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
  endtask

  task automatic test_alloc();
    next(); fetch(32'h40); upd(1, 0, 32'h40, 1, 32'h100, 0, 32'h44); want("alloc", 0, 32'h44, 1, 32'h100);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); idle(); want("alloc_hit", 1, 32'h100, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
  endtask

  task automatic test_counter();
    for (int k = 0; k < 3; k++) begin
      next(); fetch(32'h40); upd(1, 0, 32'h40, 1, 32'h100, 1, 32'h100); want("sat_up", 1, 32'h100, 0, 32'h100);
      @(negedge clk); e = q.pop_front(); total++;
      if (got() !== e.v) begin bad++; $display("FAIL %s#%0d got=%h want=%h", e.n, k, got(), e.v); end
    end
    for (int k = 0; k < 2; k++) begin
      next(); upd(1, 0, 32'h40, 0, 0, 1, 32'h100); want("decay", 1, 32'h100, 1, 32'h44);
      @(negedge clk); e = q.pop_front(); total++;
      if (got() !== e.v) begin bad++; $display("FAIL %s#%0d got=%h want=%h", e.n, k, got(), e.v); end
    end
    next(); idle(); want("weak_nt", 0, 32'h44, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); upd(1, 0, 32'h40, 0, 0, 1, 32'h100); want("nt_mis", 0, 32'h44, 1, 32'h44);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); upd(1, 0, 32'h40, 0, 0, 0, 32'h44); want("nt_ok", 0, 32'h44, 0, 32'h44);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); upd(1, 0, 32'h40, 1, 32'h100, 0, 32'h44); want("floor", 0, 32'h44, 1, 32'h100);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); upd(1, 0, 32'h40, 1, 32'h120, 1, 32'h104); want("tgt_mis", 0, 32'h44, 1, 32'h120);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); idle(); want("new_tgt", 1, 32'h120, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
  endtask

  task automatic test_conflict();
    next(); fetch(32'h40); upd(1, 0, 32'h40, 1, 32'h100, 1, 32'h120); want("re_tgt", 1, 32'h120, 1, 32'h100);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); fetch(32'h440); upd(1, 0, 32'h440, 1, 32'h200, 0, 32'h444); want("alias_alloc", 0, 32'h444, 1, 32'h200);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); fetch(32'h40); idle(); want("alias_miss", 0, 32'h44, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); fetch(32'h440); want("alias_hit", 1, 32'h200, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); upd(1, 0, 32'h840, 0, 0, 0, 32'h844); want("miss_nt", 1, 32'h200, 0, 32'h844);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); idle(); want("no_write", 1, 32'h200, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); fetch(32'h840); want("nt_absent", 0, 32'h844, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
  endtask

  task automatic test_jump();
    next(); fetch(32'h80); upd(1, 1, 32'h80, 1, 32'h300, 0, 32'h84); want("jal_alloc", 0, 32'h84, 1, 32'h300);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    for (int k = 0; k < 4; k++) begin
      next(); upd(1, 1, 32'h80, 0, 0, 1, 32'h300); want("jal_nt", 1, 32'h300, 1, 32'h84);
      @(negedge clk); e = q.pop_front(); total++;
      if (got() !== e.v) begin bad++; $display("FAIL %s#%0d got=%h want=%h", e.n, k, got(), e.v); end
    end
    next(); idle(); want("jal_sticky", 1, 32'h300, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); upd(1, 0, 32'h80, 0, 0, 1, 32'h300); want("jmp_off", 1, 32'h300, 1, 32'h84);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); idle(); want("jmp_cleared", 0, 32'h84, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
  endtask

  task automatic test_wrap();
    next(); fetch(32'h100); upd(1, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'h0); want("wrap", 0, 32'h104, 1, 32'h0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
  endtask

  task automatic test_clear();
    next(); fetch(32'h48); upd(1, 0, 32'h48, 1, 32'h500, 0, 32'h4c); want("alloc48", 0, 32'h4c, 1, 32'h500);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); idle(); want("hit48", 1, 32'h500, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); fetch(32'h40); upd(1, 0, 32'h40, 1, 32'h100, 0, 32'h44); bp_clear = 1;
    want("clr_upd", 0, 32'h44, 1, 32'h100);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); bp_clear = 0; idle(); want("clr_drop", 0, 32'h44, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); fetch(32'h48); want("clr_all", 0, 32'h4c, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
  endtask

  task automatic test_async_reset();
    next(); upd(1, 0, 32'h48, 1, 32'h500, 0, 32'h4c); want("realloc", 0, 32'h4c, 1, 32'h500);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    next(); upd(1, 0, 32'h48, 1, 32'h600, 1, 32'h500); want("pending", 1, 32'h500, 1, 32'h600);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
`ifdef BP_STATS_EN
    total++;
    if ({stat_branches, stat_mispredicts, stat_hits} !== {32'd1, 32'd1, 32'd0}) begin
      bad++; $display("FAIL stats_pre got=%h/%h/%h want=1/1/0", stat_branches, stat_mispredicts, stat_hits);
    end
`endif
    #1; rst = 1; #1; want("rst_now", 0, 32'h4c, 1, 32'h600);
    e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    idle(); #1; want("rst_idle", 0, 32'h4c, 0, 0);
    e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
    upd(1, 0, 32'h48, 1, 32'h600, 1, 32'h500);
    next(); rst = 0; idle(); want("rst_after", 0, 32'h4c, 0, 0);
    @(negedge clk); e = q.pop_front(); total++;
    if (got() !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.n, got(), e.v); end
`ifdef BP_STATS_EN
    total++;
    if ({stat_branches, stat_mispredicts, stat_hits} !== 96'd0) begin
      bad++; $display("FAIL stats_rst got=%h/%h/%h want=0/0/0", stat_branches, stat_mispredicts, stat_hits);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_conflict();
    test_jump();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
